// File: rtl/trap_pc_sequencer_pkg.sv
// Shared definitions for the trap/return PC sequencer: CSR addresses, PC mux
// select codes and the trap FSM state encoding.
package trap_pc_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Select codes shared with the PC mux; only the two trap codes originate here.
  typedef enum logic [2:0] {
    PC_NEXT   = 3'd0,
    PC_ALU    = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JUMP   = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } trap_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] pack_mstatus(input logic mie, input logic mpie);
    logic [31:0] value;
    value               = '0;
    value[MSTATUS_MIE]  = mie;
    value[MSTATUS_MPIE] = mpie;
    return value;
  endfunction

endpackage

// File: rtl/trap_pc_sequencer_sync.sv
// Multi-flop synchroniser for an asynchronous level, with a one-cycle pulse on
// each rising edge of the synchronised level.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      level_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~level_q;

endmodule

// File: rtl/trap_pc_sequencer.sv
// Machine-mode trap sequencer: owns mstatus/mtvec/mepc/mcause, latches the
// external interrupt and overrides the PC select for one cycle on trap entry/mret.
module trap_pc_sequencer
  import trap_pc_sequencer_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MCAUSE_EXT  = 32'h8000_000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        intr_in,
  input  logic        instr_done,
  input  logic        mret_exec,
  input  logic [31:0] next_pc,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wd,
  output logic [31:0] csr_rd,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic [2:0]  pc_sel,
  output logic        pc_override,
  output logic        intr_pending
);

  trap_state_e state_q, state_d;
  pc_sel_e     pc_sel_c;

  logic        mie_q, mpie_q, pending_q;
  logic [31:0] mtvec_q, mepc_q, mcause_q;
  logic        intr_rise;
  logic        in_run, take_trap, take_ret, csr_wr_ok, sw_csr_ok;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (intr_in),
    .rise (intr_rise)
  );

  assign intr_pending = pending_q & mie_q;

  assign in_run    = (state_q == ST_RUN);
  assign take_ret  = in_run && instr_done && mret_exec;
  assign take_trap = in_run && instr_done && !mret_exec && intr_pending;
  assign csr_wr_ok = in_run && csr_we;
  // Trap entry owns mstatus/mepc/mcause, so a retiring csrrw to them loses.
  assign sw_csr_ok = csr_wr_ok && !take_trap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven from always_comb gets a default up front so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (take_ret)       state_d = ST_RET;
        else if (take_trap) state_d = ST_TRAP;
      end
      ST_TRAP: state_d = ST_RUN;
      ST_RET:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_sel_c    = PC_NEXT;
    pc_override = 1'b0;
    unique case (state_q)
      ST_TRAP: begin
        pc_sel_c    = PC_MTVEC;
        pc_override = 1'b1;
      end
      ST_RET: begin
        pc_sel_c    = PC_MEPC;
        pc_override = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_sel = pc_sel_c;

  // A new edge wins over the clear so an interrupt arriving on the trap
  // cycle itself is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      pending_q <= 1'b0;
    else if (intr_rise)           pending_q <= 1'b1;
    else if (state_q == ST_TRAP)  pending_q <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_TRAP: begin
          mpie_q <= mie_q;
          mie_q  <= 1'b0;
        end
        ST_RET: begin
          mie_q  <= mpie_q;
          mpie_q <= 1'b1;
        end
        default: begin
          if (sw_csr_ok && csr_addr == CSR_MSTATUS) begin
            mie_q  <= csr_wd[MSTATUS_MIE];
            mpie_q <= csr_wd[MSTATUS_MPIE];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      mtvec_q <= word_align(MTVEC_RESET);
    else if (csr_wr_ok && csr_addr == CSR_MTVEC)  mtvec_q <= word_align(csr_wd);
  end

  // The return address is taken on the boundary edge, while next_pc is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     mepc_q <= '0;
    else if (take_trap)                          mepc_q <= word_align(next_pc);
    else if (sw_csr_ok && csr_addr == CSR_MEPC)  mepc_q <= word_align(csr_wd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       mcause_q <= '0;
    else if (state_q == ST_TRAP)                   mcause_q <= MCAUSE_EXT;
    else if (sw_csr_ok && csr_addr == CSR_MCAUSE)  mcause_q <= csr_wd;
  end

  always_comb begin
    csr_rd = '0;
    unique case (csr_addr)
      CSR_MSTATUS: csr_rd = pack_mstatus(mie_q, mpie_q);
      CSR_MTVEC:   csr_rd = mtvec_q;
      CSR_MEPC:    csr_rd = mepc_q;
      CSR_MCAUSE:  csr_rd = mcause_q;
      default:     csr_rd = '0;
    endcase
  end

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;

endmodule

// File: tb/tb_trap_pc_sequencer.sv
// Directed bench for trap_pc_sequencer: a scoreboard queue holds the expected
// override cycles, and a negedge monitor compares each one the DUT produces.
module tb_trap_pc_sequencer;
  import trap_pc_sequencer_pkg::*;

  logic        clk, rst;
  logic        intr_in, instr_done, mret_exec, csr_we;
  logic [31:0] next_pc, csr_wd, csr_rd, mtvec, mepc;
  logic [11:0] csr_addr;
  logic [2:0]  pc_sel;
  logic        pc_override, intr_pending;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] target;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  trap_pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .intr_in      (intr_in),
    .instr_done   (instr_done),
    .mret_exec    (mret_exec),
    .next_pc      (next_pc),
    .csr_we       (csr_we),
    .csr_addr     (csr_addr),
    .csr_wd       (csr_wd),
    .csr_rd       (csr_rd),
    .mtvec        (mtvec),
    .mepc         (mepc),
    .pc_sel       (pc_sel),
    .pc_override  (pc_override),
    .intr_pending (intr_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every override cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (pc_override) begin
        if (sb_q.size() == 0) begin
          check("unexpected_override", 32'(pc_sel), 32'(PC_NEXT));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("override_sel", 32'(pc_sel), 32'(e.sel));
          check("override_target", (e.sel == 3'(PC_MTVEC)) ? mtvec : mepc, e.target);
        end
      end else begin
        check("idle_sel", 32'(pc_sel), 32'(PC_NEXT));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we   = 1'b1;
    csr_addr = addr;
    csr_wd   = data;
    tick();
    csr_we   = 1'b0;
  endtask

  task automatic csr_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check(name, csr_rd, exp);
  endtask

  // One retiring instruction, followed by one idle cycle.
  task automatic boundary(input logic mret, input logic [31:0] npc);
    instr_done = 1'b1;
    mret_exec  = mret;
    next_pc    = npc;
    tick();
    instr_done = 1'b0;
    mret_exec  = 1'b0;
    tick();
  endtask

  task automatic intr_edge();
    intr_in = 1'b1;
    repeat (3) tick();
    intr_in = 1'b0;
  endtask

  task automatic expect_override(input pc_sel_e sel, input logic [31:0] target);
    exp_t e;
    e.sel    = sel;
    e.target = target;
    sb_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; intr_in = 1'b0; instr_done = 1'b0; mret_exec = 1'b0;
    csr_we = 1'b0; csr_addr = '0; csr_wd = '0; next_pc = '0;
    repeat (2) tick();

    // Reset values
    check("rst_pc_override", 32'(pc_override), 32'd0);
    check("rst_intr_pending", 32'(intr_pending), 32'd0);
    csr_check("rst_mstatus", CSR_MSTATUS, 32'h0);
    csr_check("rst_mtvec", CSR_MTVEC, 32'h0);
    csr_check("rst_mepc", CSR_MEPC, 32'h0);
    csr_check("rst_mcause", CSR_MCAUSE, 32'h0);
    rst = 1'b0;
    tick();

    // Interrupt entry
    csr_write(CSR_MTVEC, 32'h100);
    csr_write(CSR_MSTATUS, 32'h8);
    check("mtvec_port", mtvec, 32'h100);
    intr_in = 1'b1;
    tick();
    tick();
    check("pending_after_2_edges", 32'(intr_pending), 32'd0);
    tick();
    check("pending_after_3_edges", 32'(intr_pending), 32'd1);
    intr_in = 1'b0;
    expect_override(PC_MTVEC, 32'h100);
    boundary(1'b0, 32'h44);
    csr_check("t2_mepc", CSR_MEPC, 32'h44);
    csr_check("t2_mcause", CSR_MCAUSE, 32'h8000_000B);
    csr_check("t2_mstatus", CSR_MSTATUS, 32'h80);
    check("t2_intr_pending", 32'(intr_pending), 32'd0);

    // mret return
    expect_override(PC_MEPC, 32'h44);
    boundary(1'b1, 32'h48);
    csr_check("t3_mstatus", CSR_MSTATUS, 32'h88);

    // Masked interrupt is held, then taken once MIE is set
    csr_write(CSR_MSTATUS, 32'h0);
    intr_in = 1'b1;
    tick();
    intr_in = 1'b0;
    repeat (4) tick();
    check("t4_masked", 32'(intr_pending), 32'd0);
    boundary(1'b0, 32'h60);
    csr_write(CSR_MSTATUS, 32'h8);
    check("t4_unmasked", 32'(intr_pending), 32'd1);
    expect_override(PC_MTVEC, 32'h100);
    boundary(1'b0, 32'h64);
    csr_check("t4_mepc", CSR_MEPC, 32'h64);
    csr_check("t4_mstatus", CSR_MSTATUS, 32'h80);

    // mret has priority over a pending interrupt at the same boundary
    intr_edge();
    check("t5_pending_masked", 32'(intr_pending), 32'd0);
    csr_write(CSR_MSTATUS, 32'h88);
    check("t5_pending_live", 32'(intr_pending), 32'd1);
    expect_override(PC_MEPC, 32'h64);
    boundary(1'b1, 32'h70);
    check("t5_pending_after_ret", 32'(intr_pending), 32'd1);
    expect_override(PC_MTVEC, 32'h100);
    boundary(1'b0, 32'h80);
    csr_check("t5_mepc", CSR_MEPC, 32'h80);
    check("t5_pending_cleared", 32'(intr_pending), 32'd0);

    // CSR map edge cases
    csr_write(CSR_MTVEC, 32'h103);
    csr_check("t6_mtvec_align", CSR_MTVEC, 32'h100);
    csr_write(12'h7C0, 32'hFFFF_FFFF);
    csr_check("t6_unmapped", 12'h7C0, 32'h0);
    csr_check("t6_mstatus_unchanged", CSR_MSTATUS, 32'h80);
    csr_write(CSR_MSTATUS, 32'hFFFF_FFF7);
    csr_check("t6_mstatus_mask", CSR_MSTATUS, 32'h80);

    // mtvec write on the trap boundary lands; mepc write in TRAP is ignored
    csr_write(CSR_MSTATUS, 32'h8);
    intr_edge();
    expect_override(PC_MTVEC, 32'h200);
    instr_done = 1'b1; next_pc = 32'h90;
    csr_we = 1'b1; csr_addr = CSR_MTVEC; csr_wd = 32'h200;
    tick();
    instr_done = 1'b0;
    csr_addr = CSR_MEPC; csr_wd = 32'hDEAD0;
    tick();
    csr_we = 1'b0;
    csr_check("t6_mepc_hw_wins", CSR_MEPC, 32'h90);
    csr_check("t6_mcause", CSR_MCAUSE, 32'h8000_000B);
    csr_check("t6_mtvec_boundary", CSR_MTVEC, 32'h200);

    // Reset in the middle of a TRAP cycle
    csr_write(CSR_MSTATUS, 32'h8);
    intr_edge();
    instr_done = 1'b1; next_pc = 32'hA0;
    tick();
    instr_done = 1'b0;
    check("t1_in_trap", 32'(pc_override), 32'd1);
    rst = 1'b1;
    #1;
    check("t1_override_cleared", 32'(pc_override), 32'd0);
    check("t1_sel_cleared", 32'(pc_sel), 32'd0);
    csr_check("t1_mstatus", CSR_MSTATUS, 32'h0);
    csr_check("t1_mtvec", CSR_MTVEC, 32'h0);
    csr_check("t1_mepc", CSR_MEPC, 32'h0);
    csr_check("t1_mcause", CSR_MCAUSE, 32'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
